image_window_ctrl: RTL and testbench
====================================

Name: image_window_ctrl

Overview:
- Upstream producer for the 3x3 convolution engine; feeds it from a raster pixel stream.
- Accepts one 8-bit pixel per valid cycle and stores rows in four rotating line buffers.
- Emits 72-bit 3x3 windows in the byte order the convolution engine expects, and pulses an interrupt each time a line buffer is freed.
- Upstream DMA/UART logic uses the interrupt to pace row delivery.

Parameters:
- IMG_WIDTH, 512, pixels per image row; must be >= 4.
- NUM_LINES, 4, number of line buffers; fixed at 4 and not meant to be overridden.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_pixel_data  input  8  incoming raster pixel.
- i_pixel_data_valid  input  1  pixel qualifier; one pixel is accepted per high cycle.
- o_pixel_data  output  72  3x3 window (byte layout below).
- o_pixel_data_valid  output  1  window qualifier; connects to the convolution engine's valid input.
- o_intr  output  1  one-cycle pulse: one line buffer consumed, upstream may send one more row.

Behaviour:
- Reset (i_rstn low, async): o_pixel_data=0, o_pixel_data_valid=0, o_intr=0. All pointers, buffer selects and the pixel count are cleared, and the FSM goes to IDLE. Line buffer contents are don't-care.
- Write side:
  - Each valid pixel is written to buffer wr_sel at address wr_ptr.
  - wr_ptr increments and wraps from IMG_WIDTH-1 to 0. On that wrap, wr_sel advances mod 4.
- Pixel count (width clog2(4*IMG_WIDTH)+1) tracks stored, unconsumed pixels:
  - +1 per accepted pixel.
  - -IMG_WIDTH when a read row completes.
  - Both in one cycle: net change applied (+1-IMG_WIDTH).
- Read FSM:
  - IDLE -> READ when registered count >= 3*IMG_WIDTH.
  - READ: issues one window per cycle, rd_ptr = 0 .. IMG_WIDTH-3, so IMG_WIDTH-2 windows per row (valid convolution, no padding). No gaps within a row.
  - READ -> IDLE on the cycle rd_ptr = IMG_WIDTH-3 is issued. At that point rd_ptr resets to 0, rd_sel advances mod 4, and the count is decremented.
  - IDLE lasts at least one cycle between rows.
- Window assembly:
  - top row = buffer rd_sel, middle = rd_sel+1, bottom = rd_sel+2 (mod 4).
  - Columns are rd_ptr, rd_ptr+1, rd_ptr+2.
  - Byte k = row*3+col sits at bits [k*8+7:k*8]: [7:0] top-left, [31:24] middle-left, [71:64] bottom-right.
- Latency:
  - The window is registered and appears 1 cycle after issue, with o_pixel_data_valid high.
  - o_intr is high in the same cycle as the last window of a row.
  - When valid is low, o_pixel_data holds its last value.
- Input gaps: writes depend only on i_pixel_data_valid. Reading proceeds independently once 3 rows are present.
- Capacity: 4 buffers allow writing row n+3 while row n is read. At 1 pixel/cycle, reads (IMG_WIDTH-2+1 cycles/row) outpace writes, so no overflow.
- Upstream contract: never send more than one row beyond the last o_intr once 4 rows are held. Behaviour on violation is undefined.
- End of frame: no flush input. The final two rows remain stored until reset.
- Reset mid-operation: outputs drop immediately, the partial row is discarded, and 3 fresh rows are needed before the next window.

Decomposition:
- Shared package holds:
  - IMG_WIDTH default;
  - derived widths PTR_W=clog2(IMG_WIDTH) and CNT_W;
  - BUF_SEL_W=2;
  - FSM state enum {IDLE, READ}.
- Sub-module line_buffer, instantiated 4x:
  - 8-bit write port (i_data, i_data_valid);
  - i_rd_ptr input;
  - combinational 24-bit output {buf[rd_ptr+2], buf[rd_ptr+1], buf[rd_ptr]}.
- The top level keeps the muxing, count, FSM and output register.

Test Plan (IMG_WIDTH=8, pixel value = row*16+col):
- Reset: hold i_rstn low 5 cycles with random inputs -> o_pixel_data=0, o_pixel_data_valid=0, o_intr=0 throughout.
- Stream rows 0-2 (24 pixels, continuous):
  - no valid before the 24th pixel;
  - then 6 consecutive windows, the first = 72'h22_21_20_12_11_10_02_01_00 and the sixth = 72'h27_26_25_17_16_15_07_06_05;
  - o_intr high only with the sixth.
- Continue with rows 3-5 continuous -> each completed row yields 6 windows. The second batch's first window = 72'h32_31_30_22_21_20_12_11_10. Exactly one o_intr per batch, each followed by at least 1 idle cycle.
- Gapped input (valid every other cycle) for rows 0-3 -> window contents identical to the continuous case, and each row's 6 windows are back-to-back.
- Reset mid-row: pull i_rstn low during the 3rd window of a batch -> valid falls asynchronously. After release, send 2 rows and check no output. The 3rd row then gives the first window 72'h22_21_20_12_11_10_02_01_00.
- Buffer rotation: stream 10 rows -> 8 batches. The final batch's top row is row 7 (first window 72'h92_91_90_82_81_80_72_71_70), and rd_sel wraps correctly past buffer 3.

Source files
------------

// File: rtl/image_window_ctrl_pkg.sv
// Shared widths, state type and sizing helpers for the 3x3 window feeder.
package image_window_ctrl_pkg;

    localparam int IMG_WIDTH_DEF = 512;
    localparam int NUM_LINES     = 4;
    localparam int BUF_SEL_W     = 2;

    function automatic int ptr_w(input int width);
        return $clog2(width);
    endfunction

    // Count must hold four full rows, plus one bit of headroom.
    function automatic int cnt_w(input int width);
        return $clog2(NUM_LINES * width) + 1;
    endfunction

    localparam int PTR_W = ptr_w(IMG_WIDTH_DEF);
    localparam int CNT_W = cnt_w(IMG_WIDTH_DEF);

    typedef enum logic {IDLE, READ} rd_state_t;

endpackage

// File: rtl/image_window_ctrl_line_buffer.sv
// One image row of storage: synchronous byte write, combinational 3-pixel read.
// No backpressure; the caller guarantees the row being read is not being rewritten.
module line_buffer
    import image_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF
) (
    input  logic                        i_clk,
    input  logic [7:0]                  i_data,
    input  logic                        i_data_valid,
    input  logic [ptr_w(IMG_WIDTH)-1:0] i_wr_ptr,
    input  logic [ptr_w(IMG_WIDTH)-1:0] i_rd_ptr,
    output logic [23:0]                 o_data
);
    localparam int PW = ptr_w(IMG_WIDTH);

    logic [7:0] mem [IMG_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_data_valid) begin
            mem[i_wr_ptr] <= i_data;
        end
    end

    assign o_data = {mem[i_rd_ptr + PW'(2)], mem[i_rd_ptr + PW'(1)], mem[i_rd_ptr]};

endmodule

// File: rtl/image_window_ctrl.sv
// Raster pixels into four rotating line buffers, 3x3 windows out one cycle after issue.
// No input backpressure: upstream paces whole rows on o_intr, reads outpace writes.
module image_window_ctrl
    import image_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);
    localparam int PW = ptr_w(IMG_WIDTH);
    localparam int CW = cnt_w(IMG_WIDTH);

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [BUF_SEL_W-1:0] wr_sel;
    logic [BUF_SEL_W-1:0] rd_sel;
    logic [BUF_SEL_W-1:0] mid_sel;
    logic [BUF_SEL_W-1:0] bot_sel;
    logic [CW-1:0]        pix_cnt;
    rd_state_t            state;
    logic [23:0]          lb_dat [NUM_LINES];
    logic [71:0]          window;
    logic                 wr_wrap;
    logic                 row_done;

    assign wr_wrap  = i_pixel_data_valid && (wr_ptr == PW'(IMG_WIDTH - 1));
    assign row_done = (state == READ) && (rd_ptr == PW'(IMG_WIDTH - 3));
    assign mid_sel  = rd_sel + BUF_SEL_W'(1);
    assign bot_sel  = rd_sel + BUF_SEL_W'(2);
    assign window   = {lb_dat[bot_sel], lb_dat[mid_sel], lb_dat[rd_sel]};

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_lb
        line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
            .i_clk        (i_clk),
            .i_data       (i_pixel_data),
            .i_data_valid (i_pixel_data_valid && (wr_sel == BUF_SEL_W'(g))),
            .i_wr_ptr     (wr_ptr),
            .i_rd_ptr     (rd_ptr),
            .o_data       (lb_dat[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            wr_sel <= '0;
        end else if (i_pixel_data_valid) begin
            wr_ptr <= wr_wrap ? '0 : wr_ptr + PW'(1);
            if (wr_wrap) begin
                wr_sel <= wr_sel + BUF_SEL_W'(1);
            end
        end
    end

    // Stored-but-unconsumed pixels; a finished read row releases a whole buffer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pix_cnt <= '0;
        end else begin
            case ({i_pixel_data_valid, row_done})
                2'b10:   pix_cnt <= pix_cnt + CW'(1);
                2'b01:   pix_cnt <= pix_cnt - CW'(IMG_WIDTH);
                2'b11:   pix_cnt <= pix_cnt + CW'(1) - CW'(IMG_WIDTH);
                default: pix_cnt <= pix_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            rd_sel             <= '0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_cnt >= CW'(3 * IMG_WIDTH)) begin
                        state <= READ;
                    end
                end
                READ: begin
                    o_pixel_data       <= window;
                    o_pixel_data_valid <= 1'b1;
                    if (row_done) begin
                        o_intr <= 1'b1;
                        rd_ptr <= '0;
                        rd_sel <= rd_sel + BUF_SEL_W'(1);
                        state  <= IDLE;
                    end else begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Randomized-gap / scripted stimulus against a row-level window model for image_window_ctrl.
module tb_image_window_ctrl;
    localparam int W = 8;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b1;
    logic [7:0]  i_pixel_data = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    always #5 i_clk = ~i_clk;

    image_window_ctrl #(.IMG_WIDTH(W)) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the frame as a flat pixel array; once row t+2 is complete
    // the W-2 windows whose top row is t become due, the last one with o_intr.
    logic [7:0]  frame [256];
    int          npix = 0;
    logic [71:0] exp_win [$];
    bit          exp_intr [$];

    task automatic model_push(input logic [7:0] p);
        int t;
        logic [71:0] w;
        frame[npix] = p;
        npix++;
        if ((npix % W) == 0 && (npix / W) >= 3) begin
            t = npix / W - 3;
            for (int c = 0; c <= W - 3; c++) begin
                w = '0;
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        w[(r*3+k)*8 +: 8] = frame[(t + r) * W + c + k];
                exp_win.push_back(w);
                exp_intr.push_back(c == W - 3);
            end
        end
    endtask

    task automatic send_pixel(input logic [7:0] p);
        @(negedge i_clk);
        i_pixel_data       = p;
        i_pixel_data_valid = 1'b1;
        model_push(p);
    endtask

    task automatic send_idle();
        @(negedge i_clk);
        i_pixel_data_valid = 1'b0;
        i_pixel_data       = 8'($urandom);
    endtask

    // gap: 0 continuous, 1 one idle after every pixel, 2 random 0..2 idles
    task automatic send_row(input int r, input int gap, input bit rnd);
        for (int c = 0; c < W; c++) begin
            send_pixel(rnd ? 8'($urandom) : 8'(r * 16 + c));
            if (gap == 1) send_idle();
            if (gap == 2) repeat ($urandom_range(0, 2)) send_idle();
        end
    endtask

    task automatic flush_model();
        exp_win.delete();
        exp_intr.delete();
        npix = 0;
    endtask

    task automatic do_reset(input int cycles, input bit rnd_inputs);
        @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        flush_model();
        repeat (cycles) begin
            @(negedge i_clk);
            i_pixel_data       = 8'($urandom);
            i_pixel_data_valid = rnd_inputs ? 1'($urandom) : 1'b0;
        end
        @(negedge i_clk);
        i_pixel_data_valid = 1'b0;
        @(posedge i_clk);
        #2;
        i_rstn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_win.size() != 0; i++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        check("drain", exp_win.size(), 0);
    endtask

    // Monitor: scoreboard every window, row lengths, idle-time hold and reset values.
    logic [71:0] got_win [$];
    int          got_intr = 0;
    int          run = 0;
    logic [71:0] last_win = '0;

    always @(negedge i_clk) begin
        if (!i_rstn) begin
            check("rst_dat", o_pixel_data, 0);
            check("rst_vld", o_pixel_data_valid, 0);
            check("rst_intr", o_intr, 0);
            run      = 0;
            last_win = '0;
        end else if (o_pixel_data_valid) begin
            run++;
            if (exp_win.size() == 0) begin
                check("unexp_vld", 1, 0);
            end else begin
                check("win", o_pixel_data, exp_win.pop_front());
                check("intr", o_intr, exp_intr.pop_front());
            end
            got_win.push_back(o_pixel_data);
            if (o_intr) got_intr++;
            last_win = o_pixel_data;
        end else begin
            check("hold", o_pixel_data, last_win);
            check("intr_idle", o_intr, 0);
            if (run != 0) begin
                check("row_len", run, W - 2);
                run = 0;
            end
        end
    end

    task automatic clear_log();
        got_win.delete();
        got_intr = 0;
    endtask

    initial begin
        int seen;

        // Reset with random inputs; the monitor checks all outputs stay zero.
        #1 i_rstn = 1'b0;
        repeat (5) begin
            @(negedge i_clk);
            i_pixel_data       = 8'($urandom);
            i_pixel_data_valid = 1'($urandom);
        end
        @(negedge i_clk);
        i_pixel_data_valid = 1'b0;
        @(posedge i_clk);
        #2 i_rstn = 1'b1;

        // Continuous rows 0-5
        clear_log();
        for (int r = 0; r < 3; r++) send_row(r, 0, 0);
        check("no_early_vld", got_win.size(), 0);
        for (int r = 3; r < 6; r++) send_row(r, 0, 0);
        send_idle();
        drain();
        check("cont_count", got_win.size(), 24);
        check("cont_intr", got_intr, 4);
        check("cont_first", got_win[0], 72'h22_21_20_12_11_10_02_01_00);
        check("cont_sixth", got_win[5], 72'h27_26_25_17_16_15_07_06_05);
        check("cont_b2_first", got_win[6], 72'h32_31_30_22_21_20_12_11_10);

        // Valid every other cycle, rows 0-3
        do_reset(3, 0);
        clear_log();
        for (int r = 0; r < 4; r++) send_row(r, 1, 0);
        send_idle();
        drain();
        check("gap_count", got_win.size(), 12);
        check("gap_intr", got_intr, 2);
        check("gap_first", got_win[0], 72'h22_21_20_12_11_10_02_01_00);
        check("gap_sixth", got_win[5], 72'h27_26_25_17_16_15_07_06_05);
        check("gap_b2_first", got_win[6], 72'h32_31_30_22_21_20_12_11_10);

        // Reset during the third window, with a partial row 3 stored
        do_reset(3, 0);
        clear_log();
        for (int r = 0; r < 3; r++) send_row(r, 0, 0);
        send_pixel(8'h30);
        send_idle();
        seen = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(posedge i_clk);
            #1;
            if (o_pixel_data_valid) seen++;
        end
        check("mid_third_seen", seen, 3);
        #2 i_rstn = 1'b0;
        flush_model();
        #1;
        check("async_vld", o_pixel_data_valid, 0);
        check("async_dat", o_pixel_data, 0);
        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #2 i_rstn = 1'b1;
        clear_log();
        send_row(0, 0, 0);
        send_row(1, 0, 0);
        send_idle();
        repeat (20) @(negedge i_clk);
        check("two_rows_quiet", got_win.size(), 0);
        send_row(2, 0, 0);
        send_idle();
        drain();
        check("post_rst_count", got_win.size(), 6);
        check("post_rst_first", got_win[0], 72'h22_21_20_12_11_10_02_01_00);

        // Ten rows: buffer selects wrap twice
        do_reset(3, 0);
        clear_log();
        for (int r = 0; r < 10; r++) send_row(r, 0, 0);
        send_idle();
        drain();
        check("rot_count", got_win.size(), 48);
        check("rot_intr", got_intr, 8);
        check("rot_last_batch", got_win[42], 72'h92_91_90_82_81_80_72_71_70);

        // Random pixels with random input gaps
        do_reset(3, 1);
        clear_log();
        for (int r = 0; r < 12; r++) send_row(r, 2, 1);
        send_idle();
        drain();
        check("rnd_count", got_win.size(), 60);
        check("rnd_intr", got_intr, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
